// File: rtl/fir_coef_loader.sv
// FIR coefficient RAM reload sequencer.
// Streams MSB/LSB byte pairs from the host into each filter's coefficient RAM.
module fir_coef_loader #(
  parameter int NUM_FILTERS    = 4,
  parameter int QUIESCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_start,
  input  logic [8:0] coefs_per_filter,
  input  logic       abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  input  logic       audio_en_req,
  output logic       audio_en,
  input  logic       wr_addr_zero,
  output logic       coef_addr_rst,
  output logic       coefficient_wr_en,
  output logic [5:0] coef_select,
  output logic [7:0] coef_wr_msb_data,
  output logic [7:0] coef_wr_lsb_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int QW = (QUIESCE_CYCLES > 1) ? $clog2(QUIESCE_CYCLES) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QUIESCE_CYCLES - 1);
  localparam logic [5:0] FLAST = 6'(NUM_FILTERS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_QUIESCE, S_ARST, S_CHECK,
    S_MSB, S_LSB, S_WRITE, S_HOLD, S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    n_q, n_d;
  logic [8:0]    coef_q, coef_d;
  logic [5:0]    filt_q, filt_d;
  logic [5:0]    sel_q, sel_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [7:0]    msb_q, msb_d;
  logic [7:0]    lsb_q, lsb_d;
  logic          err_q, err_d;
  logic          arst_q, arst_d;
  logic          wr_q, wr_d;
  logic          aud_q, aud_d;
  logic          start, abort_hit, take;

  assign byte_ready = (state_q == S_MSB) || (state_q == S_LSB);
  assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done       = (state_q == S_FIN);
  assign abort_hit  = abort && (state_q != S_IDLE);
  // An aborted cycle never consumes the byte on offer.
  assign take       = byte_valid && byte_ready && !abort;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    coef_d  = coef_q;
    filt_d  = filt_q;
    sel_d   = sel_q;
    qcnt_d  = qcnt_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    err_d   = err_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_start && !abort) begin
          if (coefs_per_filter == 9'd0) begin
            err_d = 1'b1;
          end else begin
            start   = 1'b1;
            n_d     = coefs_per_filter;
            err_d   = 1'b0;
            filt_d  = 6'd0;
            coef_d  = 9'd0;
            qcnt_d  = '0;
            state_d = S_QUIESCE;
          end
        end
      end
      S_QUIESCE: begin
        if (qcnt_q == QLAST) state_d = S_ARST;
        else qcnt_d = qcnt_q + 1'b1;
      end
      S_ARST: state_d = S_CHECK;
      S_CHECK: begin
        if (wr_addr_zero) begin
          state_d = S_MSB;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_MSB: begin
        if (take) begin
          msb_d   = byte_data;
          state_d = S_LSB;
        end
      end
      S_LSB: begin
        if (take) begin
          lsb_d   = byte_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_HOLD;
      S_HOLD: begin
        if (coef_q != n_q - 9'd1) begin
          coef_d  = coef_q + 9'd1;
          state_d = S_MSB;
        end else if (filt_q != FLAST) begin
          filt_d  = filt_q + 6'd1;
          coef_d  = 9'd0;
          state_d = S_ARST;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end
    if (state_d == S_ARST) sel_d = filt_d;
    arst_d = (state_d == S_ARST) || abort_hit;
    wr_d   = (state_d == S_WRITE);
    // Gate audio one cycle early so it is already low after the start.
    aud_d  = audio_en_req && !(busy || start);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      coef_q  <= '0;
      filt_q  <= '0;
      sel_q   <= '0;
      qcnt_q  <= '0;
      msb_q   <= '0;
      lsb_q   <= '0;
      err_q   <= 1'b0;
      arst_q  <= 1'b0;
      wr_q    <= 1'b0;
      aud_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      coef_q  <= coef_d;
      filt_q  <= filt_d;
      sel_q   <= sel_d;
      qcnt_q  <= qcnt_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      err_q   <= err_d;
      arst_q  <= arst_d;
      wr_q    <= wr_d;
      aud_q   <= aud_d;
    end
  end

  assign coef_select       = sel_q;
  assign coef_wr_msb_data  = msb_q;
  assign coef_wr_lsb_data  = lsb_q;
  assign coef_addr_rst     = arst_q;
  assign coefficient_wr_en = wr_q;
  assign audio_en          = aud_q;
  assign error             = err_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader (NUM_FILTERS=4, QUIESCE_CYCLES=8).
// Expected writes, pulse counts and cycle counts are computed here.
module tb_fir_coef_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_start = 1'b0;
  logic [8:0] coefs_per_filter = '0;
  logic       abort = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic       byte_ready;
  logic       audio_en_req = 1'b0;
  logic       audio_en;
  logic       wr_addr_zero = 1'b1;
  logic       coef_addr_rst;
  logic       coefficient_wr_en;
  logic [5:0] coef_select;
  logic [7:0] coef_wr_msb_data;
  logic [7:0] coef_wr_lsb_data;
  logic       busy;
  logic       done;
  logic       error;

  fir_coef_loader #(.NUM_FILTERS(4), .QUIESCE_CYCLES(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .load_start        (load_start),
    .coefs_per_filter  (coefs_per_filter),
    .abort             (abort),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .audio_en_req      (audio_en_req),
    .audio_en          (audio_en),
    .wr_addr_zero      (wr_addr_zero),
    .coef_addr_rst     (coef_addr_rst),
    .coefficient_wr_en (coefficient_wr_en),
    .coef_select       (coef_select),
    .coef_wr_msb_data  (coef_wr_msb_data),
    .coef_wr_lsb_data  (coef_wr_lsb_data),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  always #5 clk = ~clk;

  int          npass = 0;
  int          ntot = 0;
  logic [7:0]  bytes [64];
  logic [21:0] wlog [$];
  int          nrst, stalls, end_cyc, hold_bad;
  bit          to, done_seen, end_err, end_rst, end_wr, aud2;
  logic [31:0] rst_snap;
  logic        extra;

  function automatic logic [31:0] outs();
    return {3'b0, byte_ready, audio_en, coef_addr_rst, coefficient_wr_en,
            busy, done, error, coef_select, coef_wr_msb_data,
            coef_wr_lsb_data};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic check_writes(input int n, input int cnt);
    chk("wr_count", 32'(wlog.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < wlog.size(); i++) begin
      chk($sformatf("wr%0d", i), {10'd0, wlog[i]},
          {10'd0, 6'(i / n), bytes[2*i], bytes[2*i+1]});
    end
  endtask

  // Runs one load from a negedge; ends when busy drops or on reset.
  task automatic run_load(input int n, input bit stall, input int abort_at,
                          input int bad_filt, input bit rst_wr);
    int          idx = 0;
    bit          fin = 0;
    int          hold_left = 0;
    logic [21:0] ref_w = '0;
    logic        v;
    wlog.delete();
    nrst = 0; stalls = 0; end_cyc = 0; hold_bad = 0;
    to = 0; done_seen = 0; end_err = 0; end_rst = 0; end_wr = 0;
    coefs_per_filter = 9'(n);
    load_start = 1'b1;
    byte_valid = 1'b0;
    for (int c = 2; c < 3000 && !fin; c++) begin
      @(negedge clk);
      load_start = 1'b0;
      abort = 1'b0;
      if (c == 2) aud2 = audio_en;
      if (coefficient_wr_en) begin
        ref_w = {coef_select, coef_wr_msb_data, coef_wr_lsb_data};
        wlog.push_back(ref_w);
        hold_left = 1;
      end else if (hold_left > 0) begin
        if ({coef_select, coef_wr_msb_data, coef_wr_lsb_data} != ref_w)
          hold_bad++;
        hold_left--;
      end
      if (coef_addr_rst) begin
        nrst++;
        if (nrst == bad_filt + 1) wr_addr_zero = 1'b0;
      end
      if (rst_wr && coefficient_wr_en) begin
        reset_n = 1'b0;
        #1 rst_snap = outs();
        fin = 1;
      end else if (!busy) begin
        fin = 1;
        end_cyc = c;
        done_seen = done;
        end_err = error;
        end_rst = coef_addr_rst;
        end_wr = coefficient_wr_en;
      end else if (abort_at >= 0 && idx == abort_at && byte_ready) begin
        abort = 1'b1;
        byte_valid = 1'b0;
      end else begin
        v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        byte_valid = v;
        byte_data = bytes[idx % 64];
        if (byte_ready) begin
          if (v) idx++;
          else stalls++;
        end
      end
    end
    if (!fin) to = 1;
    byte_valid = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bytes[i] = 8'(i * 37 + 11);
    audio_en_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_audio", {31'd0, audio_en}, 32'd1);

    // N=3, no stalls
    run_load(3, 0, -1, -1, 0);
    chk("n3_timeout", {31'd0, to}, 32'd0);
    chk("n3_done_cycle", 32'(end_cyc), 32'd66);
    chk("n3_done_seen", {31'd0, done_seen}, 32'd1);
    chk("n3_addr_rst", 32'(nrst), 32'd4);
    chk("n3_audio_gated", {31'd0, aud2}, 32'd0);
    chk("n3_hold", 32'(hold_bad), 32'd0);
    chk("n3_error", {31'd0, end_err}, 32'd0);
    check_writes(3, 12);
    @(negedge clk);
    chk("n3_audio_back", {31'd0, audio_en}, 32'd1);

    // N=5 with random host stalls
    run_load(5, 1, -1, -1, 0);
    chk("n5_timeout", {31'd0, to}, 32'd0);
    chk("n5_done_cycle", 32'(end_cyc), 32'(98 + stalls));
    chk("n5_done_seen", {31'd0, done_seen}, 32'd1);
    chk("n5_hold", 32'(hold_bad), 32'd0);
    check_writes(5, 20);
    @(negedge clk);

    // abort in LSB of filter 2
    run_load(3, 0, 13, -1, 0);
    chk("ab_timeout", {31'd0, to}, 32'd0);
    chk("ab_error", {31'd0, end_err}, 32'd1);
    chk("ab_rst_pulse", {31'd0, end_rst}, 32'd1);
    chk("ab_no_wr", {31'd0, end_wr}, 32'd0);
    chk("ab_rst_count", 32'(nrst), 32'd4);
    check_writes(3, 6);
    @(negedge clk);
    chk("ab_audio_back", {31'd0, audio_en}, 32'd1);
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      extra |= coefficient_wr_en | coef_addr_rst;
      @(negedge clk);
    end
    chk("ab_quiet", {31'd0, extra}, 32'd0);

    // abort and load_start together in IDLE
    coefs_per_filter = 9'd3;
    load_start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    abort = 1'b0;
    chk("ab_start_idle", {29'd0, busy, error, audio_en}, 32'd3);

    // wr_addr_zero fails after ARST of filter 1
    run_load(3, 0, -1, 1, 0);
    wr_addr_zero = 1'b1;
    chk("az_timeout", {31'd0, to}, 32'd0);
    chk("az_error", {31'd0, end_err}, 32'd1);
    chk("az_no_wr", {31'd0, end_wr}, 32'd0);
    chk("az_rst_count", 32'(nrst), 32'd2);
    check_writes(3, 3);
    @(negedge clk);

    // asynchronous reset in WRITE, then N=1 load
    run_load(3, 0, -1, -1, 1);
    chk("rs_timeout", {31'd0, to}, 32'd0);
    chk("rs_outputs", rst_snap, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_load(1, 0, -1, -1, 0);
    chk("n1_timeout", {31'd0, to}, 32'd0);
    chk("n1_done_cycle", 32'(end_cyc), 32'd34);
    chk("n1_done_seen", {31'd0, done_seen}, 32'd1);
    chk("n1_error", {31'd0, end_err}, 32'd0);
    check_writes(1, 4);
    @(negedge clk);

    // zero coefficient count
    coefs_per_filter = 9'd0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("z_state", {28'd0, busy, error, coefficient_wr_en, coef_addr_rst},
        32'd4);
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      extra |= busy | coefficient_wr_en | coef_addr_rst;
    end
    chk("z_quiet", {31'd0, extra}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
